// File: rtl/fetch_if_id_stage_if.sv
// Instruction-memory bus: fetch issues req/addr, memory answers with gnt and
// in-order rvalid/rdata responses.
interface fetch_if_id_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_if_id_stage.sv
// RV32 fetch stage with credit-limited instruction-memory issue, an in-order
// response FIFO, and the IF/ID register feeding decode.
module fetch_if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_i,
    input  logic                       redirect_valid_i,
    input  logic [31:0]                redirect_pc_i,
    fetch_if_id_stage_if.master        imem,
    output logic                       id_valid_o,
    output logic [31:0]                id_instr_o,
    output logic [31:0]                id_pc_o,
    output logic [31:0]                id_pc4_o
);
    localparam int             CW      = $clog2(DEPTH + 1);
    localparam int             PW      = $clog2(DEPTH);
    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];
    logic          id_valid_q, id_valid_d;
    logic [31:0]   id_instr_q, id_instr_d;
    logic [31:0]   id_pc_q, id_pc_d;

    logic   rsp, keep, fire, push, pop;
    entry_t rsp_entry;

    // Responses with nothing outstanding are protocol errors and are ignored.
    assign rsp       = imem.rvalid && (outst_q != '0);
    assign keep      = rsp && (discard_q == '0);
    assign imem.req  = !rst && !redirect_valid_i &&
                       (({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_C);
    assign imem.addr = pc_q;
    assign fire      = imem.req && imem.gnt;
    assign rsp_entry = '{instr: imem.rdata, pc: resp_pc_q};

    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_d     = fifo_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        push       = 1'b0;
        pop        = 1'b0;

        outst_d = outst_q + CW'(fire) - CW'(rsp);
        if (fire) pc_d = pc_q + 32'd4;

        if (redirect_valid_i) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d       = {redirect_pc_i[31:2], 2'b00};
            resp_pc_d  = {redirect_pc_i[31:2], 2'b00};
            discard_d  = outst_d;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            id_valid_d = 1'b0;
            id_instr_d = NOP;
        end else begin
            if (rsp && !keep) discard_d = discard_q - CW'(1);
            if (keep) resp_pc_d = resp_pc_q + 32'd4;

            if (stall_i) begin
                push = keep;
            end else if (count_q != '0) begin
                pop        = 1'b1;
                push       = keep;
                id_valid_d = 1'b1;
                id_instr_d = fifo_q[rd_ptr_q].instr;
                id_pc_d    = fifo_q[rd_ptr_q].pc;
            end else if (keep) begin
                id_valid_d = 1'b1;
                id_instr_d = rsp_entry.instr;
                id_pc_d    = rsp_entry.pc;
            end else begin
                id_valid_d = 1'b0;
                id_instr_d = NOP;
            end

            if (push) begin
                fifo_d[wr_ptr_q] = rsp_entry;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP;
            id_pc_q    <= 32'h0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign id_valid_o = id_valid_q;
    assign id_instr_o = id_instr_q;
    assign id_pc_o    = id_pc_q;
    assign id_pc4_o   = id_pc_q + 32'd4;
endmodule

// File: doc/fetch_if_id_stage.md
Name: fetch_if_id_stage

Overview:
- Fetch stage plus IF/ID pipeline register for the pipelined RV32 core.
- Generates the PC and issues requests to instruction memory.
- Buffers in-order responses in a small FIFO.
- Presents one instruction per cycle to decode, where the immediate generator and decoder consume it. Handles hazard-unit stalls and EX/CSR-trap redirects.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, FIFO entries, which also caps outstanding requests (power of 2, ≥2).
- NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- stall_i  in  1  hazard unit: hold IF/ID register.
- redirect_valid_i  in  1  branch/jump taken or CSR trap/mret; flushes the stage.
- redirect_pc_i  in  32  new fetch address; bits [1:0] ignored, treated as 0.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address, word aligned.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; responses return in order, ≥1 cycle after grant.
- imem_rdata_i  in  32  response instruction.
- id_valid_o  out  1  IF/ID holds a real instruction.
- id_instr_o  out  32  instruction to decode and immediate generation.
- id_pc_o  out  32  PC of id_instr_o.
- id_pc4_o  out  32  id_pc_o + 4, used for JAL/JALR link.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC; outstanding=0; discard=0; FIFO empty.
  - id_valid_o=0, id_instr_o=NOP, id_pc_o=0, id_pc4_o=4.
  - imem_req_o=0 in the reset cycle.
  - rst overrides all other inputs, including a redirect in the same cycle.
- Issue:
  - imem_req_o=1 when !rst && !redirect_valid_i && (outstanding + fifo_count) < DEPTH.
  - imem_addr_o=pc.
  - On req&&gnt: pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0), and outstanding increments.
  - imem_addr_o must stay stable while req=1 && gnt=0.
- Response:
  - Each rvalid decrements outstanding; a grant and an rvalid in the same cycle leave it unchanged.
  - If discard>0, the response is dropped and discard decrements.
  - Otherwise the response is kept together with its PC, taken from an internal resp_pc counter that advances by 4 per kept response.
- IF/ID load when !stall_i:
  - If FIFO non-empty: pop the head into IF/ID, with id_valid_o=1. A kept response arriving the same cycle is pushed.
  - Else if a kept response arrives: bypass it directly into IF/ID. Latency from rvalid to id_valid_o is 1 cycle.
  - Else: bubble, with id_valid_o=0, id_instr_o=NOP, and id_pc_o/id_pc4_o holding their previous values.
- stall_i=1 (no redirect):
  - IF/ID holds all outputs.
  - Kept responses are pushed into the FIFO. The issue credit rule guarantees the FIFO never overflows.
- Redirect (redirect_valid_i=1):
  - Overrides stall_i.
  - pc <= {redirect_pc_i[31:2],2'b00}; resp_pc <= the same value.
  - FIFO is cleared and IF/ID becomes a bubble (id_valid_o=0, instr=NOP).
  - discard <= outstanding − (rvalid this cycle ? 1 : 0).
  - No request is issued in the redirect cycle; fetch resumes the next cycle.
  - Back-to-back redirects: the last one wins, and discard is recomputed each time.
- Invariants:
  - outstanding ≤ DEPTH; fifo_count ≤ DEPTH; discard ≤ outstanding.
  - An rvalid arriving with outstanding=0 is a protocol error and is ignored (assertion in the bench).
- id_pc4_o is always id_pc_o+4 with 32-bit wrap, updated in the same cycle as id_pc_o.

Test Plan:
- Reset, then zero-wait memory (gnt=1, rvalid one cycle after grant) returning addr-based data → id_valid_o rises 2 cycles after the first req. id_pc_o sequence 0x0,0x4,0x8, with id_pc4_o 0x4,0x8,0xC. One instruction per cycle, no bubbles.
- Hold stall_i=1 for 4 cycles mid-stream at id_pc_o=0x8 → outputs frozen at 0x8. Issue stops once outstanding+fifo=2. On release, 0xC and 0x10 emerge in order with no loss or duplication.
- Redirect to 0x0000_0103 while 2 requests are outstanding → the next req uses addr 0x100. Both stale responses are dropped. IF/ID shows a NOP bubble, then id_pc_o=0x100.
- Redirect and stall_i asserted in the same cycle → the redirect wins and IF/ID becomes a bubble. No pc is advanced on the redirect cycle.
- gnt held at 0 for 3 cycles at addr 0x20 → imem_addr_o remains 0x20 and pc does not advance. After the grant, the response for 0x20 reaches decode.
- Set RESET_PC=0xFFFF_FFF8 and run 3 fetches → id_pc_o sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, with id_pc4_o for 0xFFFF_FFFC equal to 0x0. Assert rst mid-stream → next-cycle outputs are id_valid_o=0, id_instr_o=0x0000_0013, id_pc_o=0.
